// File: rtl/mmio_controller.sv
// Data-memory / memory-mapped I/O controller between the MEM stage and board I/O.
// RAM and I/O reads share a single registered stage, so dataout always lags addr by one cycle.
`timescale 1ns/1ps
module mmio_controller #(
    parameter int N_IN   = 3,
    parameter int IN_W   = 4,
    parameter int N_OUT  = 1,
    parameter int MEM_AW = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [31:0]             addr,
    input  logic [31:0]             datain,
    input  logic                    we,
    input  logic                    re,
    input  logic [N_IN*IN_W-1:0]    in_ports,
    output logic [31:0]             dataout,
    output logic [N_OUT*32-1:0]     out_ports
);

    localparam int DEPTH = 1 << MEM_AW;
    localparam int PW    = N_IN * IN_W;

    logic [31:0]          mem_r [DEPTH];
    logic [31:0]          ram_rdata_r;
    logic [31:0]          io_rdata_r;
    logic [31:0]          io_rdata_s;
    logic [31:0]          cnt_r;
    logic                 sel_io_r;
    logic [PW-1:0]        sync1_r;
    logic [PW-1:0]        sync2_r;
    logic [PW-1:0]        prev_r;
    logic [N_IN-1:0]      flags_r;
    logic [N_IN-1:0]      rise_s;
    logic [N_IN-1:0]      in_hit_s;
    logic [N_IN-1:0]      clr_s;
    logic [N_OUT-1:0]     out_hit_s;
    logic [N_OUT*32-1:0]  out_r;
    logic                 map_ok_s;
    logic                 stat_hit_s;
    logic                 cnt_hit_s;
    logic                 ram_we_s;
    logic [5:0]           word_s;
    logic [MEM_AW-1:0]    ram_idx_s;
    logic                 unused_s;

    // Any bit of a port going 0->1 counts as an edge for that port.
    function automatic logic port_rise(input logic [IN_W-1:0] cur, input logic [IN_W-1:0] prv);
        return |(cur & ~prv);
    endfunction

    assign unused_s = ^addr[1:0];

    // Address decode, edge detection and read-to-clear mask.
    always_comb begin
        word_s     = addr[7:2];
        map_ok_s   = addr[31] && (addr[30:8] == 23'd0);
        stat_hit_s = map_ok_s && (word_s == 6'd16);
        cnt_hit_s  = map_ok_s && (word_s == 6'd17);
        ram_we_s   = we && !addr[31];
        ram_idx_s  = addr[MEM_AW+1:2];
        for (int i = 0; i < N_IN; i++) begin
            in_hit_s[i] = map_ok_s && (word_s == 6'(i));
            rise_s[i]   = port_rise(sync2_r[i*IN_W +: IN_W], prev_r[i*IN_W +: IN_W]);
        end
        for (int k = 0; k < N_OUT; k++) begin
            out_hit_s[k] = map_ok_s && (word_s == 6'(32 + k));
        end
        clr_s = (re && stat_hit_s) ? flags_r : {N_IN{1'b0}};
    end

    // I/O read mux over pre-edge state; unmapped addresses fall through to zero.
    always_comb begin
        io_rdata_s = 32'd0;
        for (int i = 0; i < N_IN; i++) begin
            io_rdata_s = io_rdata_s | (in_hit_s[i] ? 32'(sync2_r[i*IN_W +: IN_W]) : 32'd0);
        end
        io_rdata_s = io_rdata_s | (stat_hit_s ? 32'(flags_r) : 32'd0);
        io_rdata_s = io_rdata_s | (cnt_hit_s ? cnt_r : 32'd0);
        for (int k = 0; k < N_OUT; k++) begin
            io_rdata_s = io_rdata_s | (out_hit_s[k] ? out_r[k*32 +: 32] : 32'd0);
        end
    end

    // RAM array write port; contents survive reset.
    always_ff @(posedge clock) begin
        if (ram_we_s) begin
            mem_r[ram_idx_s] <= datain;
        end
    end

    // RAM synchronous read; a same-word write in this cycle returns the old data.
    always_ff @(posedge clock) begin
        if (reset) begin
            ram_rdata_r <= 32'd0;
        end else begin
            ram_rdata_r <= mem_r[ram_idx_s];
        end
    end

    // Synchronisers, edge flags, cycle counter, output registers and I/O read stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r    <= {PW{1'b0}};
            sync2_r    <= {PW{1'b0}};
            prev_r     <= {PW{1'b0}};
            flags_r    <= {N_IN{1'b0}};
            cnt_r      <= 32'd0;
            out_r      <= {(N_OUT*32){1'b0}};
            sel_io_r   <= 1'b0;
            io_rdata_r <= 32'd0;
        end else begin
            sync1_r  <= in_ports;
            sync2_r  <= sync1_r;
            prev_r   <= sync2_r;
            flags_r  <= (flags_r & ~clr_s) | rise_s;
            // A load skips one increment-free cycle: the loaded value is already advanced.
            cnt_r    <= (we && cnt_hit_s) ? (datain + 32'd1) : (cnt_r + 32'd1);
            for (int k = 0; k < N_OUT; k++) begin
                if (we && out_hit_s[k]) begin
                    out_r[k*32 +: 32] <= datain;
                end
            end
            sel_io_r   <= addr[31];
            io_rdata_r <= io_rdata_s;
        end
    end

    assign dataout   = sel_io_r ? io_rdata_r : ram_rdata_r;
    assign out_ports = out_r;

endmodule

// File: tb/tb_mmio_controller.sv
// Directed bench for mmio_controller with default parameters (3x4-bit inputs, one output register).
`timescale 1ns/1ps
module tb_mmio_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        we;
    logic        re;
    logic [11:0] in_ports;
    logic [31:0] dataout;
    logic [31:0] out_ports;

    int total_cnt = 0;
    int bad_cnt   = 0;

    localparam logic [31:0] A_STAT = 32'h8000_0040;
    localparam logic [31:0] A_CNT  = 32'h8000_0044;
    localparam logic [31:0] A_OUT0 = 32'h8000_0080;

    mmio_controller #(.N_IN(3), .IN_W(4), .N_OUT(1), .MEM_AW(5)) dut (
        .clock     (clock),
        .reset     (reset),
        .addr      (addr),
        .datain    (datain),
        .we        (we),
        .re        (re),
        .in_ports  (in_ports),
        .dataout   (dataout),
        .out_ports (out_ports)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; re = 1'b0;
        addr = 32'd0; datain = 32'd0; in_ports = 12'h000;
        tick(); tick();
        reset = 1'b0;
        chk("rst_dataout", dataout, 32'h0000_0000);
        chk("rst_out", out_ports, 32'h0000_0000);

        // RAM write, read-back and read-during-write
        addr = 32'h0000_0010; datain = 32'hDEAD_BEEF; we = 1'b1;
        tick();
        we = 1'b0;
        tick();
        chk("ram_rd", dataout, 32'hDEAD_BEEF);
        chk("ram_out_idle", out_ports, 32'h0000_0000);
        datain = 32'h1111_1111; we = 1'b1;
        tick();
        chk("ram_rdw_old", dataout, 32'hDEAD_BEEF);
        we = 1'b0;
        tick();
        chk("ram_rdw_new", dataout, 32'h1111_1111);

        // Output register and unmapped I/O
        addr = A_OUT0; datain = 32'h1234_5678; we = 1'b1;
        tick();
        chk("out_wr", out_ports, 32'h1234_5678);
        addr = 32'h8000_0100; datain = 32'hAAAA_5555;
        tick();
        chk("out_unmapped_wr", out_ports, 32'h1234_5678);
        we = 1'b0;
        tick();
        chk("unmapped_rd", dataout, 32'h0000_0000);
        addr = 32'h8000_0082;
        tick();
        chk("out_rd_unaligned", dataout, 32'h1234_5678);
        addr = 32'h8001_0080;
        tick();
        chk("hi_bits_unmapped", dataout, 32'h0000_0000);

        // Port 1 through the synchroniser, then status read-to-clear
        in_ports = 12'h050; addr = 32'h8000_0004;
        tick(); tick();
        chk("sync_delay", dataout, 32'h0000_0000);
        tick();
        chk("sync_port1", dataout, 32'h0000_0005);
        addr = A_STAT; re = 1'b1;
        tick();
        chk("flags_first", dataout, 32'h0000_0002);
        tick();
        chk("flags_cleared", dataout, 32'h0000_0000);
        re = 1'b0;

        // New edge on port 0 coincides with clear of flag 1
        in_ports = 12'h000;
        tick(); tick(); tick();
        in_ports = 12'h050;
        tick(); tick(); tick(); tick();
        in_ports = 12'h051;
        tick(); tick();
        re = 1'b1;
        tick();
        chk("setclr_read", dataout, 32'h0000_0002);
        tick();
        chk("setclr_kept", dataout, 32'h0000_0001);
        re = 1'b0;
        tick();
        chk("setclr_empty", dataout, 32'h0000_0000);

        // Counter load and wrap
        addr = A_CNT; datain = 32'hFFFF_FFFE; we = 1'b1;
        tick();
        we = 1'b0;
        tick();
        chk("cnt_0", dataout, 32'hFFFF_FFFF);
        tick();
        chk("cnt_wrap", dataout, 32'h0000_0000);
        tick();
        chk("cnt_2", dataout, 32'h0000_0001);

        // Reset in the middle of activity, with a competing output write
        in_ports = 12'h351;
        tick(); tick(); tick();
        addr = A_STAT;
        tick();
        chk("flag2_pre", dataout, 32'h0000_0004);
        reset = 1'b1; we = 1'b1; addr = A_OUT0; datain = 32'hCAFE_F00D;
        tick();
        reset = 1'b0; we = 1'b0;
        chk("mid_rst_out", out_ports, 32'h0000_0000);
        chk("mid_rst_dataout", dataout, 32'h0000_0000);
        addr = A_CNT;
        tick();
        chk("mid_rst_cnt", dataout, 32'h0000_0000);
        addr = A_STAT;
        tick();
        chk("mid_rst_flags", dataout, 32'h0000_0000);
        chk("mid_rst_out_hold", out_ports, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/mmio_controller.md
Name: mmio_controller

Overview:
- Parametrised data-memory / memory-mapped I/O controller between the pipeline MEM stage and board I/O.
- Generalises the fixed three-input / one-display controller to N_IN input ports, N_OUT readable output registers and a configurable RAM depth.
- Adds input synchronisers, sticky rising-edge flags with read-to-clear, a loadable free-running cycle counter, and a registered read path with fixed one-cycle latency for both RAM and I/O.

Parameters:
N_IN, 3, number of input ports (1..16)
IN_W, 4, width of each input port in bits (1..32)
N_OUT, 1, number of output registers (1..16)
MEM_AW, 5, RAM word-address width; depth = 2**MEM_AW words of 32 bits

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
addr  input  32  byte address; addr[31]=1 selects I/O, else RAM
datain  input  32  write data
we  input  1  write enable
re  input  1  read strobe; qualifies read-to-clear side effects only
in_ports  input  N_IN*IN_W  port i occupies bits [i*IN_W +: IN_W]; asynchronous to clock
dataout  output  32  read data, valid one cycle after addr/re
out_ports  output  N_OUT*32  register k occupies bits [k*32 +: 32]

Behaviour:
- Reset (synchronous, reset=1 at clock edge) clears:
  - out_ports = 0, dataout = 0, edge flags = 0, cycle counter = 0, synchroniser flops = 0.
  - RAM contents are not cleared.
  - Reset dominates every write, read-clear and increment in the same cycle.
- RAM: word index addr[MEM_AW+1:2]. A write occurs when we & ~addr[31]. Read is synchronous. Read-during-write to the same word returns the old data.
- Input path: each in_ports bit passes through a 2-flop synchroniser; sync_i is the second stage.
  - Edge flag i is set when any bit of sync_i goes 0->1 versus its previous-cycle value.
- I/O map (addr[31]=1; addr[30:8] must be 0, else region is unmapped):
  - 0x8000_0000 + 4*i, i < N_IN: read {zero-extend, sync_i}. Writes ignored.
  - 0x8000_0040: read edge flags in bits [N_IN-1:0], upper bits 0.
    - Read-to-clear applies when re=1: flags returned are cleared.
    - A new edge in the same cycle sets its flag (set wins over clear).
    - Writes ignored.
  - 0x8000_0044: cycle counter; increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0.
    - A write (we=1) loads datain; the load wins over the increment. Next cycle value = datain + 1.
    - Read returns the pre-edge value.
  - 0x8000_0080 + 4*k, k < N_OUT: output register k.
    - we=1 loads datain; the value is visible on out_ports from the next cycle.
    - Read returns the current value.
  - Any other I/O address: reads 0; writes ignored with no side effects.
  - Unaligned addresses (addr[1:0] != 0): bits ignored, treated as word-aligned.
- Read latency: addr[31] and the I/O read value are registered at the same edge as RAM read. The dataout mux uses the registered select, so RAM and I/O data both appear exactly one cycle after the address.
- re=0: dataout still updates (reads are side-effect free); only read-to-clear is suppressed.
- we and re may be asserted together; each takes effect per the rules above.
- No combinational path from addr/datain to out_ports or dataout.

Test Plan:
- Reset, then write 0xDEAD_BEEF to 0x0000_0010 and read it back -> dataout=0xDEAD_BEEF exactly one cycle after the read address; out_ports=0 throughout.
- Write 0x1234_5678 to 0x8000_0080 -> out_ports[31:0]=0x1234_5678 from the next cycle. Write to 0x8000_0100 -> out_ports unchanged; reading it returns 0.
- Drive in_ports port 1 from 0x0 to 0x5 -> read of 0x8000_0004 shows 0x5 after the synchroniser delay. Read 0x8000_0040 with re=1 -> 0x2. Read it again -> 0x0.
- Raise port 0 in the same cycle as a re=1 status read that returns flag 1 -> flag 1 cleared, flag 0 set. Next read returns 0x1.
- Write 0xFFFF_FFFE to 0x8000_0044, then read on the following cycles -> counter sequence 0xFFFF_FFFF, 0x0000_0000, 0x0000_0001 (wrap checked).
- Assert reset mid-sequence with we=1 to 0x8000_0080 in the same cycle -> out_ports=0, edge flags=0, counter=0, dataout=0 on the following cycle.
